// File: rtl/lowpass_fir_1.sv
// 3-tap unsigned low-pass FIR: one shared 8x8 multiplier and one accumulator, sequenced by a 4-state FSM.
// Build option LOWPASSFIR_ROUND_EN selects round-half-up scaling instead of truncation.
module lowpass_fir_1 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] datain,
    input  logic       datavalid,
    input  logic [7:0] coeffA,
    input  logic [7:0] coeffB,
    input  logic [7:0] coeffC,
    output logic [7:0] filtout,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, MAC0, MAC1, MAC2} state_t;

    state_t      state;
    state_t      next_state;

    logic [7:0]  x0;
    logic [7:0]  x1;
    logic [7:0]  x2;
    logic [7:0]  coef_a;
    logic [7:0]  coef_b;
    logic [7:0]  coef_c;
    logic [17:0] acc;

    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] product;
    logic [17:0] sum;

    // Drop the Q0.8 fraction; the rounding variant needs one extra bit for the +128 carry.
    function automatic logic [10:0] scale(input logic [17:0] s);
`ifdef LOWPASSFIR_ROUND_EN
        logic [18:0] r;
        r = {1'b0, s} + 19'd128;
        return 11'(r >> 8);
`else
        return 11'(s >> 8);
`endif
    endfunction

    function automatic logic [7:0] sat8(input logic [10:0] v);
        return (v > 11'd255) ? 8'd255 : v[7:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The single multiplier is steered to the tap/coefficient pair of the current MAC step.
    always_comb begin
        next_state = state;
        mul_a      = coef_a;
        mul_b      = x0;
        case (state)
            IDLE: begin
                if (datavalid) begin
                    next_state = MAC0;
                end
            end
            MAC0: begin
                next_state = MAC1;
            end
            MAC1: begin
                mul_a      = coef_b;
                mul_b      = x1;
                next_state = MAC2;
            end
            MAC2: begin
                mul_a      = coef_c;
                mul_b      = x2;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign product = mul_a * mul_b;
    assign sum     = acc + {2'b00, product};

    always_ff @(posedge clk) begin
        if (reset) begin
            x0      <= 8'd0;
            x1      <= 8'd0;
            x2      <= 8'd0;
            coef_a  <= 8'd0;
            coef_b  <= 8'd0;
            coef_c  <= 8'd0;
            acc     <= 18'd0;
            filtout <= 8'd0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (datavalid) begin
                        x2     <= x1;
                        x1     <= x0;
                        x0     <= datain;
                        coef_a <= coeffA;
                        coef_b <= coeffB;
                        coef_c <= coeffC;
                        acc    <= 18'd0;
                    end
                end
                MAC0: begin
                    acc <= {2'b00, product};
                end
                MAC1: begin
                    acc <= sum;
                end
                MAC2: begin
                    filtout <= sat8(scale(sum));
                    done    <= 1'b1;
                end
                default: begin
                    acc <= 18'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lowpass_fir_1.sv
// Self-checking bench for lowpass_fir_1 against a sample-history reference model.
module tb_lowpass_fir_1;

    logic       clk;
    logic       reset;
    logic [7:0] datain;
    logic       datavalid;
    logic [7:0] coeffA;
    logic [7:0] coeffB;
    logic [7:0] coeffC;
    logic [7:0] filtout;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference history: hist[0] newest sample.
    int hist[3];

    lowpass_fir_1 dut (
        .clk       (clk),
        .reset     (reset),
        .datain    (datain),
        .datavalid (datavalid),
        .coeffA    (coeffA),
        .coeffB    (coeffB),
        .coeffC    (coeffC),
        .filtout   (filtout),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        hist[0] = 0;
        hist[1] = 0;
        hist[2] = 0;
    endfunction

    function automatic void model_push(input int s);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = s;
    endfunction

    function automatic int model_out(input int a, input int b, input int c);
        int total;
        int scaled;
        total = a * hist[0] + b * hist[1] + c * hist[2];
`ifdef LOWPASSFIR_ROUND_EN
        scaled = (total + 128) / 256;
`else
        scaled = total / 256;
`endif
        return (scaled > 255) ? 255 : scaled;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        datavalid = 1'b0;
        step();
        step();
        reset = 1'b0;
        model_reset();
    endtask

    // Drive one sample through and observe when done appears and how long it stays high.
    task automatic run_one(input int din, input int a, input int b, input int c,
                           output int out, output int done_cycle, output int done_width);
        datain     = 8'(din);
        coeffA     = 8'(a);
        coeffB     = 8'(b);
        coeffC     = 8'(c);
        datavalid  = 1'b1;
        step();
        datavalid  = 1'b0;
        out        = -1;
        done_cycle = -1;
        done_width = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (done === 1'b1) begin
                if (done_cycle < 0) begin
                    done_cycle = k;
                    out        = int'(filtout);
                end
                done_width++;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        datavalid = 1'b1;
        datain    = 8'd77;
        coeffA    = 8'd200;
        coeffB    = 8'd200;
        coeffC    = 8'd200;
        step();
        step();
        checks++;
        if (filtout !== 8'd0) begin
            errors++;
            $display("FAIL reset_filtout: got %0d expected 0", filtout);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        reset     = 1'b0;
        datavalid = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_capture cycle %0d: done=%b expected 0", k, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int expected;
        do_reset();
        datain    = 8'd200;
        coeffA    = 8'd13;
        coeffB    = 8'd14;
        coeffC    = 8'd16;
        datavalid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            if (k % 4 == 0) model_push(200);
            checks++;
            if (done !== ((k % 4) == 3)) begin
                errors++;
                $display("FAIL b2b_done cycle %0d: got %b expected %b", k, done, (k % 4) == 3);
            end
            if (k % 4 == 3) begin
                expected = model_out(13, 14, 16);
                checks++;
                if (int'(filtout) !== expected) begin
                    errors++;
                    $display("FAIL b2b_filtout cycle %0d: got %0d expected %0d", k, filtout, expected);
                end
            end
        end
        datavalid = 1'b0;
        step();
        step();
        step();
        step();
    endtask

    task automatic test_saturation();
        int out, dc, dw, expected;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_one(255, 255, 255, 255, out, dc, dw);
            model_push(255);
            expected = model_out(255, 255, 255);
            checks++;
            if (out !== expected) begin
                errors++;
                $display("FAIL sat_out %0d: got %0d expected %0d", i, out, expected);
            end
            checks++;
            if (dc !== 3 || dw !== 1) begin
                errors++;
                $display("FAIL sat_done_timing %0d: cycle %0d width %0d expected 3/1", i, dc, dw);
            end
        end
        checks++;
        if (int'(filtout) !== 255) begin
            errors++;
            $display("FAIL sat_full: got %0d expected 255", filtout);
        end
    endtask

    task automatic test_shift_order();
        int out, dc, dw, expected;
        int seq_a[3];
        int seq_b[3];
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            run_one(i, 13, 14, 16, out, dc, dw);
            model_push(i);
            expected = model_out(13, 14, 16);
            checks++;
            if (out !== expected) begin
                errors++;
                $display("FAIL incr_out %0d: got %0d expected %0d", i, out, expected);
            end
        end
        seq_a = '{0, 0, 255};
        seq_b = '{255, 0, 0};
        do_reset();
        for (int i = 0; i < 3; i++) run_one(seq_a[i], 0, 0, 255, out, dc, dw);
        checks++;
        if (out !== 0) begin
            errors++;
            $display("FAIL shift_newest_only: got %0d expected 0", out);
        end
        do_reset();
        for (int i = 0; i < 3; i++) run_one(seq_b[i], 0, 0, 255, out, dc, dw);
        checks++;
        if (out !== 254) begin
            errors++;
            $display("FAIL shift_oldest: got %0d expected 254", out);
        end
    endtask

    task automatic test_random();
        int out, dc, dw, expected, din, a, b, c;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            din = int'($urandom_range(0, 255));
            a   = int'($urandom_range(0, 255));
            b   = int'($urandom_range(0, 255));
            c   = int'($urandom_range(0, 255));
            run_one(din, a, b, c, out, dc, dw);
            model_push(din);
            expected = model_out(a, b, c);
            checks++;
            if (out !== expected || dc !== 3 || dw !== 1) begin
                errors++;
                $display("FAIL rand %0d: out %0d cyc %0d wid %0d expected %0d/3/1", i, out, dc, dw, expected);
            end
        end
    endtask

    task automatic test_mid_change();
        int out, dc, dw, expected;
        do_reset();
        datain    = 8'd100;
        coeffA    = 8'd13;
        coeffB    = 8'd14;
        coeffC    = 8'd16;
        datavalid = 1'b1;
        step();
        model_push(100);
        datavalid = 1'b0;
        step();
        datain    = 8'd255;
        coeffA    = 8'd255;
        coeffB    = 8'd255;
        coeffC    = 8'd255;
        datavalid = 1'b1;
        step();
        step();
        expected = model_out(13, 14, 16);
        checks++;
        if (done !== 1'b1 || int'(filtout) !== expected) begin
            errors++;
            $display("FAIL midchg_result: done %b out %0d expected 1/%0d", done, filtout, expected);
        end
        datavalid = 1'b0;
        step();
        run_one(0, 0, 255, 0, out, dc, dw);
        model_push(0);
        expected = model_out(0, 255, 0);
        checks++;
        if (out !== expected) begin
            errors++;
            $display("FAIL midchg_no_capture: got %0d expected %0d", out, expected);
        end
    endtask

    task automatic test_reset_mid();
        int out, dc, dw, expected;
        do_reset();
        run_one(50, 13, 14, 16, out, dc, dw);
        datain    = 8'd200;
        datavalid = 1'b1;
        step();
        datavalid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        checks++;
        if (filtout !== 8'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: out %0d done %b expected 0/0", filtout, done);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_done cycle %0d: got %b expected 0", k, done);
            end
        end
        run_one(200, 13, 14, 16, out, dc, dw);
        model_push(200);
        expected = model_out(13, 14, 16);
        checks++;
        if (out !== expected) begin
            errors++;
            $display("FAIL rstmid_taps_cleared: got %0d expected %0d", out, expected);
        end
    endtask

    initial begin
        reset     = 1'b1;
        datavalid = 1'b0;
        datain    = 8'd0;
        coeffA    = 8'd0;
        coeffB    = 8'd0;
        coeffC    = 8'd0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_saturation();
        test_shift_order();
        test_random();
        test_mid_change();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
